// File: rtl/ndn_spi_pkg.sv
// ndn_spi_pkg
// Shared constants, FSM state types and the CRC-8 helper for the NDN SPI
// slave. Imported by the slave top.
package ndn_spi_pkg;

    // Header layout: bit 7 reserved, bit 6 packet type, low bits length
    localparam int HDR_TYPE_BIT = 6;

    localparam logic PKT_INTEREST = 1'b1;
    localparam logic PKT_DATA     = 1'b0;

    // Header byte the router places in front of every outgoing data packet
    localparam logic [7:0] TX_HDR_BYTE = 8'h00;

    // CRC-8, polynomial x^8 + x^2 + x + 1, MSB first, no final xor
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_HDR    = 2'd1,
        RX_PREFIX = 2'd2,
        RX_CHECK  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LOADED = 2'd1,
        TX_SHIFT  = 2'd2
    } tx_state_e;

    // Advance the CRC by one serial bit
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ndn_spi_slave_if.sv
// ndn_spi_slave_if
// Bundles the SPI pins and the router-side RX/TX bus of the NDN SPI slave.
// Signal names carry the slave's point of view (i_ into the slave, o_ out).
//   i_sclk, i_cs_n, i_mosi : SPI from the MCU (mode 0, MSB first)
//   o_miso                 : SPI to the MCU
//   o_rx_valid/o_rx_err    : one-cycle pulses, interest accepted / rejected
//   o_rx_len, o_rx_prefix  : fields of the last accepted interest
//   i_tx_valid, i_tx_data  : data packet offered by the router
//   o_tx_ready, o_tx_busy  : TX buffer empty / TX in progress
interface ndn_spi_slave_if #(
    parameter int PREFIX_W   = 64,
    parameter int DATA_BYTES = 32,
    parameter int LEN_W      = 6
);
    logic                    i_sclk;
    logic                    i_cs_n;
    logic                    i_mosi;
    logic                    o_miso;
    logic                    o_rx_valid;
    logic [LEN_W-1:0]        o_rx_len;
    logic [PREFIX_W-1:0]     o_rx_prefix;
    logic                    o_rx_err;
    logic                    i_tx_valid;
    logic                    o_tx_ready;
    logic [8*DATA_BYTES-1:0] i_tx_data;
    logic                    o_tx_busy;

    modport slave (
        input  i_sclk, i_cs_n, i_mosi, i_tx_valid, i_tx_data,
        output o_miso, o_rx_valid, o_rx_len, o_rx_prefix, o_rx_err,
               o_tx_ready, o_tx_busy
    );

    modport master (
        output i_sclk, i_cs_n, i_mosi, i_tx_valid, i_tx_data,
        input  o_miso, o_rx_valid, o_rx_len, o_rx_prefix, o_rx_err,
               o_tx_ready, o_tx_busy
    );
endinterface

// File: rtl/ndn_spi_sync.sv
// ndn_spi_sync
// Two-flop synchronisers for sclk, cs_n and mosi plus edge detection in the
// clk domain.
//   clk, rst      : system clock, async active-high reset
//   i_sclk/i_cs_n/i_mosi : raw SPI pins
//   o_mosi        : synchronised mosi, aligned with the sclk edge strobes
//   o_sclk_rise/o_sclk_fall : one-cycle strobes per sclk edge
//   o_cs_fall/o_cs_rise     : one-cycle strobes per cs_n edge
module ndn_spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise
);
    logic       r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic       r_cs_meta,   r_cs_sync,   r_cs_prev;
    logic       r_mosi_meta, r_mosi_sync;
    logic [1:0] r_flush;
    logic       r_armed;

    // The synchronisers reset to an idle bus (cs_n high). If the pin is
    // really low when reset drops, the pipeline would show a fake falling
    // edge; r_armed only opens once cs_n has been seen high after the
    // pipeline has flushed, so a frame always needs a genuine new edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_flush     <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= i_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_flush     <= {r_flush[0], 1'b1};
            if (r_flush[1] && r_cs_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_mosi      = r_mosi_sync;
    assign o_sclk_rise =  r_sclk_sync & ~r_sclk_prev;
    assign o_sclk_fall = ~r_sclk_sync &  r_sclk_prev;
    assign o_cs_fall   = r_armed & r_cs_prev & ~r_cs_sync;
    assign o_cs_rise   = r_cs_sync & ~r_cs_prev;

endmodule

// File: rtl/ndn_spi_slave.sv
// ndn_spi_slave
// Full-duplex SPI slave (mode 0) between an MCU and the NDN router.
// RX: header byte (bit 6 = type, low LEN_W bits = length) then PREFIX_W
// prefix bits; an interest raises rx_valid, anything else raises rx_err.
// TX: a buffered data packet is sent as 8'h00 header + DATA_BYTES payload
// bytes (highest byte first) in the next cs_n frame.
// Optional feature macro: NDN_SPI_CRC_EN appends a CRC-8 byte to both
// directions and rejects RX frames whose CRC does not match.
//   clk, rst : system clock, async active-high reset
//   bus      : ndn_spi_slave_if.slave (SPI pins plus RX/TX router bus)
module ndn_spi_slave
    import ndn_spi_pkg::*;
#(
    parameter int PREFIX_W   = 64,
    parameter int DATA_BYTES = 32,
    parameter int LEN_W      = 6
) (
    input  logic           clk,
    input  logic           rst,
    ndn_spi_slave_if.slave bus
);
`ifdef NDN_SPI_CRC_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif
    localparam int RX_BODY  = PREFIX_W + CRC_BITS;
    localparam int RX_CNT_W = $clog2(RX_BODY + 1);
    localparam int TX_PAY   = 8 + 8 * DATA_BYTES;
    localparam int TX_BITS  = TX_PAY + CRC_BITS;
    localparam int TX_CNT_W = $clog2(TX_BITS + 1);

    logic w_mosi, w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

    ndn_spi_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_sclk      (bus.i_sclk),
        .i_cs_n      (bus.i_cs_n),
        .i_mosi      (bus.i_mosi),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise)
    );

    rx_state_e             r_rx_state;
    logic [RX_CNT_W-1:0]   r_rx_cnt;
    logic [HDR_TYPE_BIT-1:0] r_hdr;
    logic [PREFIX_W-1:0]   r_rx_shift;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_rx_len;
    logic [PREFIX_W-1:0]   r_rx_prefix;
    logic                  r_rx_valid;
    logic                  r_rx_err;
    logic [HDR_TYPE_BIT:0] w_hdr_next;
`ifdef NDN_SPI_CRC_EN
    logic [7:0]            r_rx_crc;
`endif

    // Header bit 7 is shifted out of the short header register on purpose;
    // at the 8th bit w_hdr_next holds header bits 6..0.
    assign w_hdr_next = {r_hdr, w_mosi};

    // RX FSM. In IDLE all sclk activity is ignored, which covers both the
    // tail of a finished frame and the rest of a rejected data-type frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_hdr       <= '0;
            r_rx_shift  <= '0;
            r_len       <= '0;
            r_rx_len    <= '0;
            r_rx_prefix <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_err    <= 1'b0;
`ifdef NDN_SPI_CRC_EN
            r_rx_crc    <= CRC8_INIT;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_cs_fall) begin
                        r_rx_state <= RX_HDR;
                        r_rx_cnt   <= '0;
`ifdef NDN_SPI_CRC_EN
                        r_rx_crc   <= CRC8_INIT;
`endif
                    end
                end
                RX_HDR: begin
                    if (w_cs_rise) begin
                        r_rx_err   <= 1'b1;
                        r_rx_state <= RX_IDLE;
                    end else if (w_sclk_rise) begin
                        r_hdr    <= w_hdr_next[HDR_TYPE_BIT-1:0];
                        r_rx_cnt <= r_rx_cnt + 1'b1;
`ifdef NDN_SPI_CRC_EN
                        r_rx_crc <= crc8_step(r_rx_crc, w_mosi);
`endif
                        if (r_rx_cnt == RX_CNT_W'(7)) begin
                            r_rx_cnt <= '0;
                            if (w_hdr_next[HDR_TYPE_BIT] == PKT_DATA) begin
                                r_rx_err   <= 1'b1;
                                r_rx_state <= RX_IDLE;
                            end else begin
                                r_len      <= w_hdr_next[LEN_W-1:0];
                                r_rx_state <= RX_PREFIX;
                            end
                        end
                    end
                end
                RX_PREFIX: begin
                    if (w_cs_rise) begin
                        r_rx_err   <= 1'b1;
                        r_rx_state <= RX_IDLE;
                    end else if (w_sclk_rise) begin
                        if (r_rx_cnt < RX_CNT_W'(PREFIX_W)) begin
                            r_rx_shift <= {r_rx_shift[PREFIX_W-2:0], w_mosi};
                        end
`ifdef NDN_SPI_CRC_EN
                        r_rx_crc <= crc8_step(r_rx_crc, w_mosi);
`endif
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                        if (r_rx_cnt == RX_CNT_W'(RX_BODY - 1)) begin
                            r_rx_state <= RX_CHECK;
                        end
                    end
                end
                RX_CHECK: begin
                    r_rx_state <= RX_IDLE;
`ifdef NDN_SPI_CRC_EN
                    // Running the CRC over the received CRC byte too leaves
                    // zero exactly when the byte matched.
                    if (r_rx_crc == 8'h00) begin
                        r_rx_valid  <= 1'b1;
                        r_rx_len    <= r_len;
                        r_rx_prefix <= r_rx_shift;
                    end else begin
                        r_rx_err <= 1'b1;
                    end
`else
                    r_rx_valid  <= 1'b1;
                    r_rx_len    <= r_len;
                    r_rx_prefix <= r_rx_shift;
`endif
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    tx_state_e           r_tx_state;
    logic [TX_PAY-1:0]   r_tx_shift;
    logic [TX_CNT_W-1:0] r_tx_cnt;
    logic                w_tx_bit;
`ifdef NDN_SPI_CRC_EN
    logic [7:0]          r_tx_crc;
`endif

    // TX FSM. The current bit sits on miso from cs_n falling (or the
    // previous sclk fall) until the next sclk fall, as mode 0 requires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
`ifdef NDN_SPI_CRC_EN
            r_tx_crc   <= CRC8_INIT;
`endif
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (bus.i_tx_valid) begin
                        r_tx_shift <= {TX_HDR_BYTE, bus.i_tx_data};
                        r_tx_state <= TX_LOADED;
                    end
                end
                TX_LOADED: begin
                    if (w_cs_fall) begin
                        r_tx_state <= TX_SHIFT;
                        r_tx_cnt   <= '0;
`ifdef NDN_SPI_CRC_EN
                        r_tx_crc   <= CRC8_INIT;
`endif
                    end
                end
                TX_SHIFT: begin
                    if (w_cs_rise) begin
                        r_tx_state <= TX_IDLE;
                    end else if (w_sclk_fall) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        if (r_tx_cnt < TX_CNT_W'(TX_PAY)) begin
                            r_tx_shift <= {r_tx_shift[TX_PAY-2:0], 1'b0};
`ifdef NDN_SPI_CRC_EN
                            r_tx_crc   <= crc8_step(r_tx_crc, r_tx_shift[TX_PAY-1]);
                        end else begin
                            r_tx_crc   <= {r_tx_crc[6:0], 1'b0};
`endif
                        end
                        if (r_tx_cnt == TX_CNT_W'(TX_BITS - 1)) begin
                            r_tx_state <= TX_IDLE;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef NDN_SPI_CRC_EN
    assign w_tx_bit = (r_tx_cnt < TX_CNT_W'(TX_PAY)) ? r_tx_shift[TX_PAY-1] : r_tx_crc[7];
`else
    assign w_tx_bit = r_tx_shift[TX_PAY-1];
`endif

    assign bus.o_miso      = (r_tx_state == TX_SHIFT) ? w_tx_bit : 1'b1;
    assign bus.o_tx_ready  = (r_tx_state == TX_IDLE);
    assign bus.o_tx_busy   = (r_tx_state != TX_IDLE);
    assign bus.o_rx_valid  = r_rx_valid;
    assign bus.o_rx_err    = r_rx_err;
    assign bus.o_rx_len    = r_rx_len;
    assign bus.o_rx_prefix = r_rx_prefix;

endmodule

// File: tb/tb_ndn_spi_slave.sv
// tb_ndn_spi_slave
// Directed bench for ndn_spi_slave: an SPI master task drives frames, the
// expected RX events and MISO bytes are queued as stimulus is issued, and
// two monitors pop and compare whenever the DUT presents an RX pulse or a
// completed MISO byte. Define NDN_SPI_CRC_EN to exercise the CRC build.
`timescale 1ns/1ps
module tb_ndn_spi_slave;

    localparam int PW = 64;
    localparam int DB = 32;
    localparam int LW = 6;
`ifdef NDN_SPI_CRC_EN
    localparam int CRCB = 8;
`else
    localparam int CRCB = 0;
`endif
    localparam int TXB = 8 + 8 * DB + CRCB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            isErr;
        logic [LW-1:0] len;
        logic [PW-1:0] prefix;
    } rxExp_t;

    rxExp_t     rxExpQ[$];
    logic [7:0] txExpQ[$];

    ndn_spi_slave_if #(.PREFIX_W(PW), .DATA_BYTES(DB), .LEN_W(LW)) bus ();

    ndn_spi_slave #(.PREFIX_W(PW), .DATA_BYTES(DB), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tbCrc8(input logic [511:0] bits, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            if ((c[7] ^ bits[n-1-i]) == 1'b1) c = {c[6:0], 1'b0} ^ 8'h07;
            else                               c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rx_valid"},  64'(bus.o_rx_valid), 64'd0);
        checkOutput({tag, "_rx_err"},    64'(bus.o_rx_err),   64'd0);
        checkOutput({tag, "_rx_len"},    64'(bus.o_rx_len),   64'd0);
        checkOutput({tag, "_rx_prefix"}, bus.o_rx_prefix,     64'd0);
        checkOutput({tag, "_miso"},      64'(bus.o_miso),     64'd1);
        checkOutput({tag, "_tx_ready"},  64'(bus.o_tx_ready), 64'd1);
        checkOutput({tag, "_tx_busy"},   64'(bus.o_tx_busy),  64'd0);
    endtask

    // SPI master, mode 0: mosi set while sclk low, sclk half period 50 ns.
    // rstAt >= 0 asserts rst before that bit and abandons the frame.
    task automatic applyStimulus(input logic [511:0] bits, input int n, input int rstAt);
        bus.i_cs_n = 1'b0;
        #100;
        for (int i = 0; i < n; i++) begin
            if (i == rstAt) begin
                rst = 1'b1;
                #50;
                checkReset("mid_rst");
                rst = 1'b0;
                #100;
                bus.i_cs_n = 1'b1;
                #200;
                return;
            end
            bus.i_mosi = bits[n-1-i];
            #50 bus.i_sclk = 1'b1;
            #50 bus.i_sclk = 1'b0;
        end
        #100 bus.i_cs_n = 1'b1;
        bus.i_mosi = 1'b0;
        #300;
    endtask

    task automatic pushRx(input bit isErr, input logic [LW-1:0] len, input logic [PW-1:0] prefix);
        rxExp_t e;
        e.isErr  = isErr;
        e.len    = len;
        e.prefix = prefix;
        rxExpQ.push_back(e);
    endtask

    // Interest frame, optional CRC byte (optionally corrupted), then nExtra
    // trailing ones that must be ignored.
    task automatic sendInterest(input logic [7:0] hdr, input logic [PW-1:0] prefix,
                                input int nExtra, input bit badCrc, input logic [LW-1:0] expLen);
        logic [511:0] bits;
        int n;
`ifdef NDN_SPI_CRC_EN
        logic [7:0] crc;
`endif
        bits = {448'h0, hdr, prefix};
        n = 72;
`ifdef NDN_SPI_CRC_EN
        crc = tbCrc8(bits, 72) ^ (badCrc ? 8'h01 : 8'h00);
        bits = (bits << 8) | {504'h0, crc};
        n = n + 8;
`endif
        bits = bits << nExtra;
        for (int j = 0; j < nExtra; j++) bits[j] = 1'b1;
        n = n + nExtra;
        pushRx(badCrc, expLen, prefix);
        applyStimulus(bits, n, -1);
    endtask

    task automatic loadTx(input logic [8*DB-1:0] data);
        @(negedge clk);
        bus.i_tx_valid = 1'b1;
        bus.i_tx_data  = data;
        @(negedge clk);
        bus.i_tx_valid = 1'b0;
    endtask

    // RX monitor: every rx pulse must match the head of the queue
    always @(negedge clk) begin : rxMon
        rxExp_t e;
        if (!rst && (bus.o_rx_valid || bus.o_rx_err)) begin
            if (rxExpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rx_unexpected: valid=%0b err=%0b, expected no event",
                         bus.o_rx_valid, bus.o_rx_err);
            end else begin
                e = rxExpQ.pop_front();
                checkOutput("rx_err_pulse",   64'(bus.o_rx_err),   64'(e.isErr));
                checkOutput("rx_valid_pulse", 64'(bus.o_rx_valid), 64'(!e.isErr));
                if (!e.isErr) begin
                    checkOutput("rx_len",    64'(bus.o_rx_len), 64'(e.len));
                    checkOutput("rx_prefix", bus.o_rx_prefix,   e.prefix);
                end
            end
        end
    end

    // MISO monitor: assembles bytes as the master samples them
    logic [7:0] txByte = 8'h00;
    logic [7:0] txExp;
    int         txBitCnt = 0;
    always @(posedge bus.i_sclk or posedge bus.i_cs_n) begin
        if (bus.i_cs_n) begin
            txBitCnt = 0;
        end else begin
            txByte = {txByte[6:0], bus.o_miso};
            txBitCnt++;
            if (txBitCnt == 8) begin
                txBitCnt = 0;
                if (txExpQ.size() > 0) begin
                    txExp = txExpQ.pop_front();
                    checkOutput("miso_byte", 64'(txByte), 64'(txExp));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [511:0] bits;
        logic [511:0] txBits;
        bus.i_sclk     = 1'b0;
        bus.i_cs_n     = 1'b1;
        bus.i_mosi     = 1'b0;
        bus.i_tx_valid = 1'b0;
        bus.i_tx_data  = '0;
        rst = 1'b1;
        #40;
        checkReset("in_rst");
        #20 rst = 1'b0;
        #100;
        checkReset("post_rst");

        // Basic interest frame
        sendInterest(8'h48, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 6'h08);

        // Data-type header rejected after 8 bits, trailing byte ignored
        pushRx(1'b1, '0, '0);
        bits = {496'h0, 8'h08, 8'hFF};
        applyStimulus(bits, 16, -1);

        // Frame cut after 40 prefix bits, then a good frame
        pushRx(1'b1, '0, '0);
        bits = {464'h0, 8'h48, 40'hDE_ADBE_EF55};
        applyStimulus(bits, 48, -1);
        sendInterest(8'hC5, 64'hFEDC_BA98_7654_3210, 0, 1'b0, 6'h05);

        // Extra bits after a complete frame are ignored
        sendInterest(8'h7F, 64'hA5A5_0000_FFFF_1234, 16, 1'b0, 6'h3F);

        // Full-duplex: data packet out while an interest comes in
        loadTx({8'hA5, 248'h0});
        checkOutput("tx_ready_loaded", 64'(bus.o_tx_ready), 64'd0);
        checkOutput("tx_busy_loaded",  64'(bus.o_tx_busy),  64'd1);
        checkOutput("miso_loaded_idle", 64'(bus.o_miso),   64'd1);
        loadTx({8'h3C, 248'h0});
        txExpQ.push_back(8'h00);
        txExpQ.push_back(8'hA5);
        for (int k = 0; k < DB - 1; k++) txExpQ.push_back(8'h00);
`ifdef NDN_SPI_CRC_EN
        txBits = {248'h0, 8'h00, 8'hA5, 248'h0};
        txExpQ.push_back(tbCrc8(txBits, 264));
`endif
        pushRx(1'b0, 6'h01, 64'h1111_2222_3333_4444);
        bits = '0;
        bits[TXB-1 -: 72] = {8'h41, 64'h1111_2222_3333_4444};
`ifdef NDN_SPI_CRC_EN
        txBits = {440'h0, 8'h41, 64'h1111_2222_3333_4444};
        bits[TXB-73 -: 8] = tbCrc8(txBits, 72);
`else
        txBits = '0;
`endif
        applyStimulus(bits, TXB, -1);
        checkOutput("tx_ready_after", 64'(bus.o_tx_ready), 64'd1);
        checkOutput("tx_busy_after",  64'(bus.o_tx_busy),  64'd0);
        checkOutput("miso_after",     64'(bus.o_miso),     64'd1);

        // Reset at prefix bit 20 with TX loaded, then a clean frame
        loadTx({8'h77, 248'h1});
        bits = {440'h0, 8'h48, 64'h0123_4567_89AB_CDEF};
        applyStimulus(bits, 72, 28);
        sendInterest(8'h4A, 64'h0F0F_1234_5678_F0F0, 0, 1'b0, 6'h0A);

`ifdef NDN_SPI_CRC_EN
        // Corrupted CRC rejected, correct CRC accepted
        sendInterest(8'h48, 64'h0123_4567_89AB_CDEF, 0, 1'b1, 6'h08);
        sendInterest(8'h48, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 6'h08);
`endif

        #500;
        checkOutput("rx_events_left", 64'(rxExpQ.size()), 64'd0);
        checkOutput("tx_bytes_left",  64'(txExpQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ndn_spi_slave.md
NDN_SPI_SLAVE -- requirements
Module: ndn_spi_slave

Interface
REQ-001 SHALL have parameter PREFIX_W, default 64, meaning interest prefix width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTES, default 32, meaning data-packet payload length in bytes.
REQ-003 SHALL have parameter LEN_W, default 6, meaning header length-field width.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sclk  input  1  MCU SPI clock, asynchronous to clk, mode 0.
REQ-007 cs_n  input  1  MCU chip select, active-low frame.
REQ-008 mosi  input  1  MCU-to-router serial data, MSB first.
REQ-009 miso  output  1  router-to-MCU serial data, MSB first.
REQ-010 rx_valid  output  1  one-cycle pulse; interest fields valid.
REQ-011 rx_len  output  LEN_W  received prefix length field.
REQ-012 rx_prefix  output  PREFIX_W  received interest prefix.
REQ-013 rx_err  output  1  one-cycle pulse; frame rejected.
REQ-014 tx_valid  input  1  data packet offered for transmission.
REQ-015 tx_ready  output  1  high when TX buffer empty.
REQ-016 tx_data  input  8*DATA_BYTES  payload, byte DATA_BYTES-1 sent first.
REQ-017 tx_busy  output  1  high from TX accept until last bit shifted.

Function
REQ-018 sclk, cs_n, mosi SHALL pass a 2-flop synchroniser; rising/falling sclk edges derived from synchronised samples.
REQ-019 mosi SHALL be sampled on sclk rising edges while cs_n low; miso SHALL update on sclk falling edges.
REQ-020 RX FSM states IDLE, HDR, PREFIX, CHECK; IDLE->HDR on cs_n falling edge.
REQ-021 HDR SHALL collect 8 bits: bit7 ignored, bit6 type (1 interest, 0 data), bits LEN_W-1:0 length.
REQ-022 Type 0 header SHALL pulse rx_err at header completion and return RX FSM to IDLE, ignoring bits until cs_n rises.
REQ-023 PREFIX SHALL collect PREFIX_W bits then enter CHECK; CHECK SHALL pulse rx_valid one cycle, holding rx_len/rx_prefix until next rx_valid.
REQ-024 rx_valid SHALL assert within 4 clk cycles of the final sclk rising edge at the pin.
REQ-025 cs_n rising before frame completion SHALL pulse rx_err and return to IDLE without rx_valid.
REQ-026 Bits clocked after frame completion in the same cs_n frame SHALL be ignored.
REQ-027 TX FSM states IDLE, LOADED, SHIFT; tx_valid && tx_ready SHALL latch tx_data and enter LOADED.
REQ-028 LOADED->SHIFT on next cs_n falling edge; frame = header byte 8'h00 then DATA_BYTES payload bytes.
REQ-029 miso SHALL be high whenever TX is not SHIFT or cs_n is high.
REQ-030 cs_n rising during SHIFT SHALL abort TX, drop the buffer, return to IDLE, tx_ready high.
REQ-031 RX and TX SHALL operate concurrently in the same frame (full duplex).
REQ-032 tx_valid while tx_ready low SHALL be ignored.

Reset
REQ-033 On rst: rx_valid=0, rx_err=0, rx_len=0, rx_prefix=0, miso=1, tx_ready=1, tx_busy=0, both FSMs IDLE, synchronisers reset to cs_n=1, sclk=0.
REQ-034 rst mid-frame SHALL discard all partial RX/TX state; next reception requires a new cs_n falling edge.

Configuration
REQ-035 Macro NDN_SPI_CRC_EN defined: RX frame carries trailing CRC-8 (poly 0x07, init 0x00) over header+prefix; CHECK pulses rx_err instead of rx_valid on mismatch; TX appends CRC-8 over header+payload.
REQ-036 NDN_SPI_CRC_EN undefined: no CRC byte on RX or TX; CHECK always pulses rx_valid.

Structure
REQ-037 Package ndn_spi_pkg SHALL hold packet-type constants, header bit positions, CRC polynomial, RX/TX state enums.
REQ-038 Sub-module ndn_spi_sync SHALL implement synchronisers and sclk edge detection.

Verification
REQ-039 Interest header 8'h48, prefix 64'h0123_4567_89AB_CDEF -> one rx_valid, rx_len=6'h08, rx_prefix=64'h0123_4567_89AB_CDEF.
REQ-040 Header 8'h08 (type data) -> rx_err pulse after 8th bit, no rx_valid.
REQ-041 cs_n raised after 40 prefix bits -> rx_err pulse, no rx_valid; following full frame received correctly.
REQ-042 tx_data with byte31=8'hA5, rest 0, then 264-bit frame -> miso 8'h00, 8'hA5, zeros; tx_ready high after.
REQ-043 rst asserted at prefix bit 20 -> outputs at reset values; next complete frame yields correct rx_valid.
REQ-044 NDN_SPI_CRC_EN defined, corrupted CRC byte -> rx_err, no rx_valid; correct CRC -> rx_valid.
